// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit: one bit per cycle shift-add
// multiply and restoring divide, with early-out for divide special cases.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic [2:0]          op_r;
    logic [TAG_W-1:0]    tag_r;
    logic                qneg_r;
    logic                rneg_r;
    logic [XLEN-1:0]     hi_r;
    logic [XLEN-1:0]     lo_r;
    logic [XLEN-1:0]     mcand_r;
    logic [CW-1:0]       cnt_r;
    logic [XLEN-1:0]     res_r;
    logic [TAG_W-1:0]    otag_r;

    logic                accept_s;
    logic                last_s;
    logic                a_signed_s;
    logic                b_signed_s;
    logic                a_neg_s;
    logic                b_neg_s;
    logic [XLEN-1:0]     mag_a_s;
    logic [XLEN-1:0]     mag_b_s;
    logic                div_zero_s;
    logic                div_ovf_s;
    logic                early_s;
    logic [XLEN-1:0]     early_res_s;
    logic [XLEN:0]       sum_s;
    logic [XLEN:0]       trial_s;
    logic [XLEN-1:0]     hi_nxt_s;
    logic [XLEN-1:0]     lo_nxt_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quo_s;
    logic [XLEN-1:0]     rem_s;
    logic [XLEN-1:0]     final_s;

    assign in_ready   = (state_r == IDLE) && !kill;
    assign out_valid  = (state_r == DONE);
    assign out_result = res_r;
    assign out_tag    = otag_r;
    assign accept_s   = in_valid && in_ready;
    assign last_s     = (cnt_r == CNT_LAST);

    // Request decode: operand signedness, magnitudes and divide special cases.
    always_comb begin
        a_signed_s  = (in_op == OP_MULH) || (in_op == OP_MULHSU) ||
                      (in_op == OP_DIV)  || (in_op == OP_REM);
        b_signed_s  = (in_op == OP_MULH) || (in_op == OP_DIV) || (in_op == OP_REM);
        a_neg_s     = a_signed_s && in_a[XLEN-1];
        b_neg_s     = b_signed_s && in_b[XLEN-1];
        mag_a_s     = a_neg_s ? (~in_a + {{(XLEN-1){1'b0}}, 1'b1}) : in_a;
        mag_b_s     = b_neg_s ? (~in_b + {{(XLEN-1){1'b0}}, 1'b1}) : in_b;
        div_zero_s  = in_op[2] && (in_b == '0);
        div_ovf_s   = in_op[2] && !in_op[0] && (in_a == XMIN) && (in_b == '1);
        early_s     = div_zero_s || div_ovf_s;
        early_res_s = '0;
        if (div_zero_s) begin
            early_res_s = in_op[1] ? in_a : '1;
        end else if (div_ovf_s) begin
            early_res_s = in_op[1] ? '0 : XMIN;
        end else begin
            early_res_s = '0;
        end
    end

    // One iteration step; hi holds partial product / remainder, lo the multiplier / quotient.
    always_comb begin
        sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mcand_r} : {(XLEN+1){1'b0}});
        trial_s = {hi_r, lo_r[XLEN-1]};
        if (op_r[2]) begin
            if (trial_s >= {1'b0, mcand_r}) begin
                hi_nxt_s = trial_s[XLEN-1:0] - mcand_r;
                lo_nxt_s = {lo_r[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt_s = trial_s[XLEN-1:0];
                lo_nxt_s = {lo_r[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_nxt_s = sum_s[XLEN:1];
            lo_nxt_s = {sum_s[0], lo_r[XLEN-1:1]};
        end
    end

    // Sign fix-up and result selection from the final iteration step.
    always_comb begin
        prod_s  = qneg_r ? (~{hi_nxt_s, lo_nxt_s} + {{(2*XLEN-1){1'b0}}, 1'b1})
                         : {hi_nxt_s, lo_nxt_s};
        quo_s   = qneg_r ? (~lo_nxt_s + {{(XLEN-1){1'b0}}, 1'b1}) : lo_nxt_s;
        rem_s   = rneg_r ? (~hi_nxt_s + {{(XLEN-1){1'b0}}, 1'b1}) : hi_nxt_s;
        final_s = '0;
        case (op_r)
            OP_MUL:                        final_s = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_s = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               final_s = quo_s;
            OP_REM, OP_REMU:               final_s = rem_s;
            default:                       final_s = '0;
        endcase
    end

    // Next-state logic; kill wins over completion and over the output handshake.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = early_s ? DONE : CALC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                if (kill) begin
                    state_nxt_s = IDLE;
                end else if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CALC;
                end
            end
            DONE: begin
                if (kill || out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath; result and tag registers are non-zero only while in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r    <= 3'b000;
            tag_r   <= '0;
            qneg_r  <= 1'b0;
            rneg_r  <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
            mcand_r <= '0;
            cnt_r   <= '0;
            res_r   <= '0;
            otag_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r   <= in_op;
                        tag_r  <= in_tag;
                        qneg_r <= a_neg_s ^ b_neg_s;
                        rneg_r <= a_neg_s;
                        hi_r   <= '0;
                        cnt_r  <= '0;
                        if (in_op[2]) begin
                            lo_r    <= mag_a_s;
                            mcand_r <= mag_b_s;
                        end else begin
                            lo_r    <= mag_b_s;
                            mcand_r <= mag_a_s;
                        end
                        if (early_s) begin
                            res_r  <= early_res_s;
                            otag_r <= in_tag;
                        end
                    end
                end
                CALC: begin
                    hi_r  <= hi_nxt_s;
                    lo_r  <= lo_nxt_s;
                    cnt_r <= cnt_r + 1'b1;
                    if (!kill && last_s) begin
                        res_r  <= final_s;
                        otag_r <= tag_r;
                    end
                end
                DONE: begin
                    if (kill || out_ready) begin
                        res_r  <= '0;
                        otag_r <= '0;
                    end
                end
                default: begin
                    res_r  <= '0;
                    otag_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, random ops against an
// arithmetic reference model, and hand-written backpressure/abort sequences.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_tag;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;

    int vectors     = 0;
    int miscompares = 0;

    muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .kill(kill),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the RV32M definitions.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        int              ia = $signed(a);
        int              ib = $signed(b);
        logic [63:0]     p;
        case (op)
            3'd0: begin p = ua * ub;           return p[31:0];  end
            3'd1: begin p = sa * sb;           return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub;           return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[2] && b == 32'd0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Present a request; returns just after the accept edge with inputs scrambled.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] tag, input string name);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
        check({name, " in_ready before accept"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op  = 3'($urandom);
        in_a   = 32'($urandom);
        in_b   = 32'($urandom);
        in_tag = 5'($urandom);
    endtask

    // Wait for out_valid; lat is the cycle number counted from the accept cycle.
    task automatic wait_valid(output int lat, output bit zero_ok);
        lat = 0;
        zero_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && (out_result !== 32'd0 || out_tag !== 5'd0)) zero_ok = 1'b0;
        end while (!out_valid && lat < 40);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] exp, input int exp_lat,
                          input string name);
        int lat;
        bit zero_ok;
        start_op(op, a, b, tag, name);
        wait_valid(lat, zero_ok);
        check({name, " out_valid seen"}, 64'(out_valid), 64'd1);
        if (out_valid) begin
            check({name, " latency"}, 64'(lat), 64'(exp_lat));
            check({name, " result"}, 64'(out_result), 64'(exp));
            check({name, " tag"}, 64'(out_tag), 64'(tag));
            check({name, " zero while invalid"}, 64'(zero_ok), 64'd1);
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
            check({name, " in_ready after consume"}, 64'(in_ready), 64'd1);
            check({name, " out_result cleared"}, 64'(out_result), 64'd0);
        end
    endtask

    task automatic no_valid_for(input int cycles, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check({name, " no out_valid"}, 64'(seen), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_res;
        logic [4:0]  held_tag;
        int          lat;
        bit          zero_ok;
        bit          stable;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;

        tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
        tbl[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        tbl[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        tbl[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
        tbl[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
        tbl[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        tbl[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
        tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};

        rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_a = 32'd0; in_b = 32'd0;
        in_tag = 5'd0; kill = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_result", 64'(out_result), 64'd0);
        check("reset out_tag", 64'(out_tag), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 5'(i + 3), tbl[i].exp, tbl[i].lat,
                   $sformatf("dir%0d", i));
        end

        for (int i = 0; i < 200; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = pick_operand();
            b   = pick_operand();
            tag = 5'($urandom);
            run_op(op, a, b, tag, ref_result(op, a, b), ref_latency(op, a, b),
                   $sformatf("rnd%0d op%0d a=%h b=%h", i, op, a, b));
        end

        // Backpressure: result and tag must hold while out_ready is low.
        start_op(3'd0, 32'd12345, 32'd678, 5'd21, "bp");
        wait_valid(lat, zero_ok);
        check("bp out_valid seen", 64'(out_valid), 64'd1);
        check("bp result", 64'(out_result), 64'(32'd12345 * 32'd678));
        held_res = out_result;
        held_tag = out_tag;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_result !== held_res || out_tag !== held_tag || in_ready !== 1'b0 ||
                out_valid !== 1'b1) stable = 1'b0;
        end
        check("bp stable under backpressure", 64'(stable), 64'd1);
        check("bp tag", 64'(out_tag), 64'd21);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("bp in_ready after release", 64'(in_ready), 64'd1);

        // Kill in CALC cycle 5.
        start_op(3'd4, 32'd1000, 32'd3, 5'd9, "kill");
        repeat (5) @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        check("kill in_ready cycle 6", 64'(in_ready), 64'd1);
        no_valid_for(40, "kill");

        // Reset in CALC cycle 10.
        start_op(3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd30, "rst");
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_result", 64'(out_result), 64'd0);
        check("rst out_tag", 64'(out_tag), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        no_valid_for(40, "rst");

        // Kill with in_valid in IDLE blocks acceptance.
        @(negedge clk);
        in_valid = 1'b1; kill = 1'b1; in_op = 3'd5; in_a = 32'd5; in_b = 32'd0; in_tag = 5'd7;
        #1 check("idle kill in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 begin in_valid = 1'b0; kill = 1'b0; end
        @(negedge clk);
        check("idle kill still idle", 64'(in_ready), 64'd1);
        no_valid_for(40, "idle kill");

        // Unit still works after the abort sequences.
        run_op(3'd7, 32'd100, 32'd7, 5'd4, 32'd2, 33, "post-abort");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
